// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register: state encoding and default widths.
package pipe_pkg;

  localparam int unsigned DEF_DATA_W = 64;
  localparam int unsigned DEF_CTRL_W = 5;
  localparam int unsigned DEF_RD_W   = 5;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

endpackage

// File: rtl/pipe_slot.sv
// One storage slot of the stage: a load-enabled {ctrl, data, rd} register cleared by async reset.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W = DEF_CTRL_W,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned RD_W   = DEF_RD_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic [DATA_W-1:0] d_data,
  input  logic [RD_W-1:0]   d_rd,
  output logic [CTRL_W-1:0] q_ctrl,
  output logic [DATA_W-1:0] q_data,
  output logic [RD_W-1:0]   q_rd
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_ctrl <= '0;
      q_data <= '0;
      q_rd   <= '0;
    end else if (load) begin
      q_ctrl <= d_ctrl;
      q_data <= d_data;
      q_rd   <= d_rd;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with a skid slot: full-throughput valid/ready handshake
// where in_ready is registered and never depends combinationally on out_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned CTRL_W = DEF_CTRL_W,
  parameter int unsigned RD_W   = DEF_RD_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic [RD_W-1:0]   in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [RD_W-1:0]   out_rd,
  output logic [1:0]        occupancy
);

  state_e state_q, state_d;
  logic   in_fire, out_fire;
  logic   load_main, load_skid, main_from_skid;

  logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_d_ctrl;
  logic [DATA_W-1:0] main_data, skid_data, main_d_data;
  logic [RD_W-1:0]   main_rd,   skid_rd,   main_d_rd;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // Next-state and slot load control; flush overrides everything.
  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          load_main = 1'b1;
          state_d   = ST_ONE;
        end
      end
      ST_ONE: begin
        if (in_fire && !out_fire) begin
          load_skid = 1'b1;
          state_d   = ST_FULL;
        end else if (in_fire && out_fire) begin
          load_main = 1'b1;
        end else if (out_fire) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_fire) begin
          load_main      = 1'b1;
          main_from_skid = 1'b1;
          state_d        = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush) begin
      state_d        = ST_EMPTY;
      load_main      = 1'b0;
      load_skid      = 1'b0;
      main_from_skid = 1'b0;
    end
  end

  // State plus the status outputs, all registered from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_EMPTY;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      occupancy <= 2'd0;
    end else begin
      state_q   <= state_d;
      in_ready  <= (state_d != ST_FULL);
      out_valid <= (state_d != ST_EMPTY);
      occupancy <= 2'(state_d);
    end
  end

  assign main_d_ctrl = main_from_skid ? skid_ctrl : in_ctrl;
  assign main_d_data = main_from_skid ? skid_data : in_data;
  assign main_d_rd   = main_from_skid ? skid_rd   : in_rd;

  pipe_slot #(
    .CTRL_W(CTRL_W),
    .DATA_W(DATA_W),
    .RD_W  (RD_W)
  ) u_main (
    .clk   (clk),
    .reset (reset),
    .load  (load_main),
    .d_ctrl(main_d_ctrl),
    .d_data(main_d_data),
    .d_rd  (main_d_rd),
    .q_ctrl(main_ctrl),
    .q_data(main_data),
    .q_rd  (main_rd)
  );

  pipe_slot #(
    .CTRL_W(CTRL_W),
    .DATA_W(DATA_W),
    .RD_W  (RD_W)
  ) u_skid (
    .clk   (clk),
    .reset (reset),
    .load  (load_skid),
    .d_ctrl(in_ctrl),
    .d_data(in_data),
    .d_rd  (in_rd),
    .q_ctrl(skid_ctrl),
    .q_data(skid_data),
    .q_rd  (skid_rd)
  );

  // Control is forced to a bubble whenever nothing is presented downstream.
  assign out_ctrl = out_valid ? main_ctrl : '0;
  assign out_data = main_data;
  assign out_rd   = main_rd;

endmodule
